// File: rtl/reg_dump_reader_if.sv
// Bus bundle between reg_dump_reader and its surroundings: start/status,
// register-file user read port and the outgoing valid/ready byte stream.
// master = the dump reader, slave = the environment (register file + sink).
interface reg_dump_reader_if;
   logic        start;
   logic [31:0] reg_data;
   logic [4:0]  user_addr;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;

   modport master (
      input  start,
      input  reg_data,
      input  tx_ready,
      output user_addr,
      output tx_data,
      output tx_valid,
      output busy,
      output done
   );

   modport slave (
      output start,
      output reg_data,
      output tx_ready,
      input  user_addr,
      input  tx_data,
      input  tx_valid,
      input  busy,
      input  done
   );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register indices FIRST_REG..LAST_REG on the register
// file's user read port, snapshots each 32-bit word and streams it out as four
// bytes over a valid/ready byte interface.
// Optional feature: define REG_DUMP_CSUM_EN to append one XOR checksum byte
// covering every data byte of the dump.
module reg_dump_reader #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               CLK,
   input  logic               RST_N,
   reg_dump_reader_if.master  bus
);

   if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_param_check
      $error("reg_dump_reader: parameters must satisfy 0 <= FIRST_REG <= LAST_REG <= 31");
   end

   localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
   localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_LOAD = 3'd2,
      S_SEND = 3'd3,
`ifdef REG_DUMP_CSUM_EN
      S_CSUM = 3'd4,
`endif
      S_DONE = 3'd5
   } state_t;

   state_t      state_q,    state_d;
   logic [4:0]  addr_q,     addr_d;
   logic [31:0] word_q,     word_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [7:0]  tx_data_q,  tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        busy_q,     busy_d;
   logic        done_q,     done_d;
`ifdef REG_DUMP_CSUM_EN
   logic [7:0]  csum_q,     csum_d;
`endif

   logic        handshake;

   // Picks stream byte idx (0 = first sent) out of a word in the configured order.
   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      logic [1:0] lane;
      lane = MSB_FIRST ? (2'd3 - idx) : idx;
      case (lane)
         2'd0:    byte_sel = w[7:0];
         2'd1:    byte_sel = w[15:8];
         2'd2:    byte_sel = w[23:16];
         default: byte_sel = w[31:24];
      endcase
   endfunction

   assign handshake = tx_valid_q && bus.tx_ready;

   // Next-state and registered-output logic for the dump sequencer.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      done_d     = 1'b0;
`ifdef REG_DUMP_CSUM_EN
      csum_d     = csum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               addr_d  = FIRST_ADDR;
`ifdef REG_DUMP_CSUM_EN
               csum_d  = 8'h00;
`endif
               state_d = S_ADDR;
            end
         end

         // user_addr is already driven; give the combinational read path a cycle.
         S_ADDR: begin
            state_d = S_LOAD;
         end

         // Snapshot the word so later register writes cannot disturb bytes in flight.
         S_LOAD: begin
            word_d     = bus.reg_data;
            byte_idx_d = 2'd0;
            tx_data_d  = byte_sel(bus.reg_data, 2'd0);
            tx_valid_d = 1'b1;
            state_d    = S_SEND;
         end

         S_SEND: begin
            if (handshake) begin
`ifdef REG_DUMP_CSUM_EN
               csum_d = csum_q ^ tx_data_q;
`endif
               if (byte_idx_q != 2'd3) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  tx_data_d  = byte_sel(word_q, byte_idx_q + 2'd1);
               end else if (addr_q != LAST_ADDR) begin
                  addr_d     = addr_q + 5'd1;
                  tx_valid_d = 1'b0;
                  state_d    = S_ADDR;
               end else begin
`ifdef REG_DUMP_CSUM_EN
                  // Checksum byte includes the byte completing right now.
                  tx_data_d  = csum_q ^ tx_data_q;
                  state_d    = S_CSUM;
`else
                  tx_valid_d = 1'b0;
                  done_d     = 1'b1;
                  state_d    = S_DONE;
`endif
               end
            end
         end

`ifdef REG_DUMP_CSUM_EN
         S_CSUM: begin
            if (handshake) begin
               tx_valid_d = 1'b0;
               done_d     = 1'b1;
               state_d    = S_DONE;
            end
         end
`endif

         S_DONE: begin
            addr_d  = FIRST_ADDR;
            state_d = S_IDLE;
         end

         default: begin
            state_d    = S_IDLE;
            addr_d     = FIRST_ADDR;
            tx_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset abandons any dump in progress.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         addr_q     <= FIRST_ADDR;
         word_q     <= 32'h0;
         byte_idx_q <= 2'd0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
         csum_q     <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef REG_DUMP_CSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.user_addr = addr_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
